hyperram_responder: RTL and testbench

- Synthesizable HyperBus target (memory side) that pairs with the wb_hyperram controller.
- It answers controller transactions from an internal 16-bit word array plus a small register space.
- Used inside user-project testbenches and FPGA loopback builds so the controller's CA, latency, read, write and timeout paths can be exercised without a vendor HyperRAM model.
- It oversamples the bus: HyperBus CK is edge-detected in the system clock domain.

---
 rtl/hyperbus_pkg.sv | 31 +++
 rtl/hyperram_responder_if.sv | 25 ++
 rtl/hyperram_resp_mem.sv | 25 ++
 rtl/hyperram_responder.sv | 129 ++++++++++++
 tb/tb_hyperram_responder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hyperbus_pkg.sv
// Shared HyperBus target definitions: CA field positions, register map, FSM states
// and the burst address-advance helper.
package hyperbus_pkg;

  localparam int CA_RW = 47;
  localparam int CA_AS = 46;
  localparam int CA_BT = 45;

  localparam logic [31:0] REG_ID0 = 32'h0000_0000;
  localparam logic [31:0] REG_CR0 = 32'h0000_0800;

  localparam int WRAP_WORDS = 16;
  localparam int WRAP_BITS  = $clog2(WRAP_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CA,
    ST_LAT,
    ST_RD,
    ST_WR,
    ST_REGWR,
    ST_DONE
  } state_e;

  // Wrapped bursts stay inside an aligned WRAP_WORDS group.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic linear);
    if (linear) return a + 32'd1;
    return {a[31:WRAP_BITS], a[WRAP_BITS-1:0] + WRAP_BITS'(1)};
  endfunction

endpackage

// File: rtl/hyperram_responder_if.sv
// HyperBus pins between a controller (master) and the responder (slave),
// plus the responder's stall control and busy status.
interface hyperram_responder_if;
  logic       hb_reset_n_i;
  logic       hb_cs_n_i;
  logic       hb_ck_i;
  logic [7:0] hb_dq_i;
  logic [7:0] hb_dq_o;
  logic       hb_dq_oe_o;
  logic       hb_rwds_i;
  logic       hb_rwds_o;
  logic       hb_rwds_oe_o;
  logic       stall_i;
  logic       busy_o;

  modport master (
    output hb_reset_n_i, hb_cs_n_i, hb_ck_i, hb_dq_i, hb_rwds_i, stall_i,
    input  hb_dq_o, hb_dq_oe_o, hb_rwds_o, hb_rwds_oe_o, busy_o
  );

  modport slave (
    input  hb_reset_n_i, hb_cs_n_i, hb_ck_i, hb_dq_i, hb_rwds_i, stall_i,
    output hb_dq_o, hb_dq_oe_o, hb_rwds_o, hb_rwds_oe_o, busy_o
  );
endinterface

// File: rtl/hyperram_resp_mem.sv
// Single-port 16-bit word array: registered read, per-byte write enable,
// read returns the pre-write contents when reading and writing the same word.
module hyperram_resp_mem #(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = $clog2(WORDS)
) (
  input  logic          clk_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  input  logic [1:0]    we_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [WORDS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i[1]) mem_q[addr_i][15:8] <= wdata_i[15:8];
    if (we_i[0]) mem_q[addr_i][7:0]  <= wdata_i[7:0];
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/hyperram_responder.sv
// HyperBus memory-side target: oversamples CK in the system clock domain and serves
// CA / latency / read / write / register transactions from a word array and CR0.
module hyperram_responder
  import hyperbus_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LATENCY_CK = 6,
  parameter int unsigned FIXED_2X   = 1,
  parameter logic [15:0] ID0_VAL    = 16'h0C81,
  parameter logic [15:0] CR0_RST    = 16'h8F1F
) (
  input logic                wb_clk_i,
  input logic                wb_rst_i,
  hyperram_responder_if.slave hb
);

  localparam int unsigned AW        = $clog2(MEM_WORDS);
  localparam logic [7:0]  LAT_EDGES = 8'(2 * LATENCY_CK * (1 + FIXED_2X) - 4);
  localparam logic        RWDS_CA   = (FIXED_2X != 0);

  state_e      state_q;
  logic        ck_q, cs_n_q;
  logic [39:0] ca_q;
  logic [2:0]  ca_cnt_q;
  logic [7:0]  lat_cnt_q;
  logic [31:0] addr_q;
  logic        rd_q, as_q, lin_q;
  logic [7:0]  hi_q;
  logic [15:0] cr0_q;
  logic [7:0]  dq_q;
  logic        dq_oe_q, rwds_q, rwds_oe_q;

  logic        edge_d, rise_d;
  logic [31:0] ca_addr_d, addr_nxt_d;
  logic [15:0] rd_word_d, mem_rdata;
  logic [7:0]  rd_byte_d;
  logic [1:0]  mem_we_d;

  always_comb begin
    edge_d     = (ck_q != hb.hb_ck_i) && !hb.hb_cs_n_i;
    rise_d     = hb.hb_ck_i;
    ca_addr_d  = {ca_q[36:8], hb.hb_dq_i[2:0]};
    addr_nxt_d = next_addr(addr_q, lin_q);
    if (!as_q)                  rd_word_d = mem_rdata;
    else if (addr_q == REG_ID0) rd_word_d = ID0_VAL;
    else if (addr_q == REG_CR0) rd_word_d = cr0_q;
    else                        rd_word_d = 16'h0000;
    rd_byte_d = rise_d ? rd_word_d[15:8] : rd_word_d[7:0];
    // RWDS high from the controller masks that byte.
    mem_we_d = 2'b00;
    if (state_q == ST_WR && edge_d && !hb.hb_rwds_i && hb.hb_reset_n_i)
      mem_we_d = rise_d ? 2'b10 : 2'b01;
  end

  hyperram_resp_mem #(.WORDS(MEM_WORDS)) u_mem (
    .clk_i   (wb_clk_i),
    .addr_i  (addr_q[AW-1:0]),
    .wdata_i ({hb.hb_dq_i, hb.hb_dq_i}),
    .we_i    (mem_we_d),
    .rdata_o (mem_rdata)
  );

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;  ck_q <= 1'b0;  cs_n_q <= 1'b1;
      ca_q <= '0;  ca_cnt_q <= '0;  lat_cnt_q <= '0;  addr_q <= '0;
      rd_q <= 1'b0;  as_q <= 1'b0;  lin_q <= 1'b0;  hi_q <= '0;
      cr0_q <= CR0_RST;
      dq_q <= '0;  dq_oe_q <= 1'b0;  rwds_q <= 1'b0;  rwds_oe_q <= 1'b0;
    end else begin
      ck_q   <= hb.hb_ck_i;
      cs_n_q <= hb.hb_cs_n_i;
      if (!hb.hb_reset_n_i) begin
        state_q <= ST_IDLE;  cr0_q <= CR0_RST;
        dq_q <= '0;  dq_oe_q <= 1'b0;  rwds_q <= 1'b0;  rwds_oe_q <= 1'b0;
      end else if (hb.hb_cs_n_i) begin
        // CS high beats any CK edge seen in the same cycle.
        state_q <= ST_IDLE;
        dq_q <= '0;  dq_oe_q <= 1'b0;  rwds_q <= 1'b0;  rwds_oe_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: if (cs_n_q) begin
            state_q <= ST_CA;  ca_cnt_q <= '0;
            rwds_oe_q <= 1'b1;  rwds_q <= RWDS_CA;
          end
          ST_CA: if (edge_d) begin
            ca_q     <= {ca_q[31:0], hb.hb_dq_i};
            ca_cnt_q <= ca_cnt_q + 3'd1;
            if (ca_cnt_q == 3'd5) begin
              rwds_oe_q <= 1'b0;  rwds_q <= 1'b0;
              rd_q      <= ca_q[CA_RW-8];
              as_q      <= ca_q[CA_AS-8];
              lin_q     <= ca_q[CA_BT-8];
              addr_q    <= ca_addr_d;
              lat_cnt_q <= LAT_EDGES;
              state_q   <= (!ca_q[CA_RW-8] && ca_q[CA_AS-8]) ? ST_REGWR : ST_LAT;
            end
          end
          ST_LAT: if (edge_d) begin
            if (lat_cnt_q == 8'd1) state_q <= rd_q ? ST_RD : ST_WR;
            else                   lat_cnt_q <= lat_cnt_q - 8'd1;
          end
          ST_RD: if (edge_d && !hb.stall_i) begin
            dq_q <= rd_byte_d;  rwds_q <= rise_d;
            dq_oe_q <= 1'b1;  rwds_oe_q <= 1'b1;
            if (!rise_d) addr_q <= addr_nxt_d;
          end
          ST_WR: if (edge_d && !rise_d) addr_q <= addr_nxt_d;
          ST_REGWR: if (edge_d) begin
            if (rise_d) hi_q <= hb.hb_dq_i;
            else begin
              if (addr_q == REG_CR0) cr0_q <= {hi_q, hb.hb_dq_i};
              state_q <= ST_DONE;
            end
          end
          ST_DONE: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign hb.hb_dq_o      = dq_q;
  assign hb.hb_dq_oe_o   = dq_oe_q;
  assign hb.hb_rwds_o    = rwds_q;
  assign hb.hb_rwds_oe_o = rwds_oe_q;
  assign hb.busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hyperram_responder.sv
// Drives HyperBus transactions as a controller; a forked monitor checks every read byte
// against a queue of hand-computed {rwds, dq} pairs.
module tb_hyperram_responder;

  logic wb_clk_i = 1'b0;
  logic wb_rst_i;
  always #5 wb_clk_i = ~wb_clk_i;

  hyperram_responder_if hb ();

  hyperram_responder #(
    .MEM_WORDS(1024), .LATENCY_CK(6), .FIXED_2X(1),
    .ID0_VAL(16'h0C81), .CR0_RST(16'h8F1F)
  ) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .hb       (hb)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [8:0]  exp_q[$];
  logic [15:0] wdat [16];
  logic [1:0]  wmsk [16];
  logic [15:0] edat [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic       po, pr;
    logic [8:0] e;
    po = 1'b0;
    pr = 1'b0;
    forever begin
      @(negedge wb_clk_i);
      if (hb.hb_dq_oe_o && (!po || hb.hb_rwds_o != pr)) begin
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL unexpected_byte: got %h expected none", {hb.hb_rwds_o, hb.hb_dq_o});
        end else begin
          e = exp_q.pop_front();
          chk("rd_byte", 32'({hb.hb_rwds_o, hb.hb_dq_o}), 32'(e));
        end
      end
      po = hb.hb_dq_oe_o;
      pr = hb.hb_rwds_o;
    end
  endtask

  function automatic logic [47:0] mk_ca(input logic rd, input logic as, input logic lin,
                                        input logic [31:0] a);
    return {rd, as, lin, a[31:3], 13'b0, a[2:0]};
  endfunction

  task automatic tick(input logic [7:0] d, input logic m);
    hb.hb_dq_i   = d;
    hb.hb_rwds_i = m;
    hb.hb_ck_i   = ~hb.hb_ck_i;
    repeat (2) @(negedge wb_clk_i);
  endtask

  task automatic cs_start(input logic [47:0] ca, input int nbytes);
    hb.hb_cs_n_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    chk("ca_rwds_oe", 32'(hb.hb_rwds_oe_o), 32'd1);
    chk("ca_rwds", 32'(hb.hb_rwds_o), 32'd1);
    for (int i = 0; i < nbytes; i++) tick(ca[47-8*i -: 8], 1'b0);
  endtask

  task automatic cs_end();
    hb.hb_cs_n_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    hb.hb_ck_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    chk("idle_busy", 32'(hb.busy_o), 32'd0);
    chk("idle_oe", 32'({hb.hb_dq_oe_o, hb.hb_rwds_oe_o}), 32'd0);
  endtask

  task automatic latency();
    repeat (20) tick(8'h00, 1'b0);
    chk("lat_no_oe", 32'(hb.hb_dq_oe_o), 32'd0);
  endtask

  task automatic mem_write(input logic [31:0] a, input logic lin, input int n);
    cs_start(mk_ca(1'b0, 1'b0, lin, a), 6);
    latency();
    for (int i = 0; i < n; i++) begin
      tick(wdat[i][15:8], wmsk[i][1]);
      tick(wdat[i][7:0], wmsk[i][0]);
    end
    cs_end();
  endtask

  task automatic rd(input logic as, input logic lin, input logic [31:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, edat[i][15:8]});
      exp_q.push_back({1'b0, edat[i][7:0]});
    end
    cs_start(mk_ca(1'b1, as, lin, a), 6);
    latency();
    repeat (2 * n) tick(8'h00, 1'b0);
    cs_end();
    chk("all_bytes_seen", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [15:0] w);
    cs_start(mk_ca(1'b0, 1'b1, 1'b1, a), 6);
    tick(w[15:8], 1'b0);
    tick(w[7:0], 1'b0);
    cs_end();
  endtask

  initial begin
    wb_rst_i        = 1'b1;
    hb.hb_reset_n_i = 1'b1;
    hb.hb_cs_n_i    = 1'b1;
    hb.hb_ck_i      = 1'b0;
    hb.hb_dq_i      = 8'h00;
    hb.hb_rwds_i    = 1'b0;
    hb.stall_i      = 1'b0;
    fork
      monitor();
    join_none
    repeat (3) @(negedge wb_clk_i);
    chk("rst_busy", 32'(hb.busy_o), 32'd0);
    chk("rst_oe", 32'({hb.hb_dq_oe_o, hb.hb_rwds_oe_o}), 32'd0);
    chk("rst_outs", 32'({hb.hb_rwds_o, hb.hb_dq_o}), 32'd0);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Linear write / read-back at word 5
    wdat[0] = 16'h1234; wmsk[0] = 2'b00;
    wdat[1] = 16'hABCD; wmsk[1] = 2'b00;
    mem_write(32'd5, 1'b1, 2);
    edat[0] = 16'h1234; edat[1] = 16'hABCD;
    rd(1'b0, 1'b1, 32'd5, 2);

    // High byte masked
    wdat[0] = 16'h0000; wmsk[0] = 2'b00;
    mem_write(32'd7, 1'b1, 1);
    wdat[0] = 16'hFFFF; wmsk[0] = 2'b10;
    mem_write(32'd7, 1'b1, 1);
    edat[0] = 16'h00FF;
    rd(1'b0, 1'b1, 32'd7, 1);

    // Wrapped read across the 16-word group boundary
    for (int i = 0; i < 16; i++) begin
      wdat[i] = 16'(32'h20 + i);
      wmsk[i] = 2'b00;
    end
    mem_write(32'h20, 1'b1, 16);
    edat[0] = 16'h002E; edat[1] = 16'h002F; edat[2] = 16'h0020; edat[3] = 16'h0021;
    rd(1'b0, 1'b0, 32'h2E, 4);

    // Register space
    edat[0] = 16'h0C81;
    rd(1'b1, 1'b1, 32'h0, 1);
    reg_write(32'h800, 16'h8F17);
    edat[0] = 16'h8F17;
    rd(1'b1, 1'b1, 32'h800, 1);
    reg_write(32'h001, 16'h1111);
    rd(1'b1, 1'b1, 32'h800, 1);

    // Stalled read never drives the bus
    hb.stall_i = 1'b1;
    cs_start(mk_ca(1'b1, 1'b0, 1'b1, 32'd5), 6);
    latency();
    for (int i = 0; i < 4; i++) begin
      tick(8'h00, 1'b0);
      chk("stall_oe", 32'({hb.hb_dq_oe_o, hb.hb_rwds_oe_o}), 32'd0);
    end
    chk("stall_busy", 32'(hb.busy_o), 32'd1);
    cs_end();
    hb.stall_i = 1'b0;

    // Abort after 3 CA bytes, then a normal read
    cs_start(mk_ca(1'b1, 1'b0, 1'b1, 32'd5), 3);
    hb.hb_cs_n_i = 1'b1;
    @(negedge wb_clk_i);
    chk("abort_busy", 32'(hb.busy_o), 32'd0);
    chk("abort_rwds_oe", 32'(hb.hb_rwds_oe_o), 32'd0);
    cs_end();
    edat[0] = 16'h1234;
    rd(1'b0, 1'b1, 32'd5, 1);

    // Async reset in the middle of a read
    exp_q.push_back({1'b1, 8'h12});
    exp_q.push_back({1'b0, 8'h34});
    cs_start(mk_ca(1'b1, 1'b0, 1'b1, 32'd5), 6);
    latency();
    tick(8'h00, 1'b0);
    tick(8'h00, 1'b0);
    @(posedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_oe", 32'({hb.hb_dq_oe_o, hb.hb_rwds_oe_o}), 32'd0);
    chk("arst_busy", 32'(hb.busy_o), 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i     = 1'b0;
    hb.hb_cs_n_i = 1'b1;
    repeat (2) @(negedge wb_clk_i);
    chk("arst_bytes", 32'(exp_q.size()), 32'd0);
    edat[0] = 16'h8F1F;
    rd(1'b1, 1'b1, 32'h800, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
